// File: rtl/dispatch_int.sv
// dispatch_int: holds one renamed group of DISPATCH_WIDTH micro-ops and
// forwards it to the integer issue queue, tracking physical-register
// busy state so each source can be flagged as waiting on a tag-bus broadcast.
//
// micro_op_pkg carries the shared micro-op constants and type (the
// common/micro_op.svh definitions) so this file is self-contained.
//
// Handshake: uop_in is taken on a cycle where rename_stall is low, flush is
// low and at least one lane is valid; uop_out carries a group only on the
// cycle it is sent (send = FULL & ~iq_int_full & ~flush), otherwise zero.
// iq_int_full is only ever consumed, never derived from uop_out.
//
// Optional build macro: DISPATCH_INT_PERF_EN adds perf_stall_cycles and
// perf_groups_sent saturating counters.
package micro_op_pkg;
  localparam int DISPATCH_WIDTH     = 4;
  localparam int ISSUE_WIDTH_INT    = 3;
  localparam int PRF_INT_INDEX_SIZE = 6;
  localparam int PRF_INT_SIZE       = 1 << PRF_INT_INDEX_SIZE;

  typedef struct packed {
    logic                          valid;
    logic [15:0]                   pc;
    logic                          rs1_valid;
    logic [PRF_INT_INDEX_SIZE-1:0] rs1_prf_int_index;
    logic                          rs2_valid;
    logic [PRF_INT_INDEX_SIZE-1:0] rs2_prf_int_index;
    logic                          rd_valid;
    logic [PRF_INT_INDEX_SIZE-1:0] rd_prf_int_index;
  } micro_op_t;
endpackage

module dispatch_int
  import micro_op_pkg::*;
(
  input  logic                                                 clock,
  input  logic                                                 reset,
  input  logic                                                 flush,
  input  micro_op_t [DISPATCH_WIDTH-1:0]                       uop_in,
  output logic                                                 rename_stall,
  input  logic                                                 iq_int_full,
  input  logic [ISSUE_WIDTH_INT-1:0][PRF_INT_INDEX_SIZE-1:0]   ctb_prf_int_index,
  input  logic [ISSUE_WIDTH_INT-1:0]                           ctb_valid,
  output micro_op_t [DISPATCH_WIDTH-1:0]                       uop_out,
  output logic [DISPATCH_WIDTH-1:0]                            rs1_from_ctb,
  output logic [DISPATCH_WIDTH-1:0]                            rs2_from_ctb,
  output logic                                                 dbg_state,
  output logic [PRF_INT_SIZE-1:0]                              dbg_busy
`ifdef DISPATCH_INT_PERF_EN
  ,
  output logic [31:0]                                          perf_stall_cycles,
  output logic [31:0]                                          perf_groups_sent
`endif
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t                          state;
  micro_op_t [DISPATCH_WIDTH-1:0]  held;
  micro_op_t [DISPATCH_WIDTH-1:0]  uop_masked;
  logic [PRF_INT_SIZE-1:0]         busy;
  logic [PRF_INT_SIZE-1:0]         busy_next;
  logic                            send;
  logic                            accept;
  logic                            any_valid;

  assign dbg_state = state;
  assign dbg_busy  = busy;

  // True when any valid tag-bus lane broadcasts idx this cycle.
  function automatic logic ctb_hit(
    input logic [ISSUE_WIDTH_INT-1:0][PRF_INT_INDEX_SIZE-1:0] tags,
    input logic [ISSUE_WIDTH_INT-1:0]                         vld,
    input logic [PRF_INT_INDEX_SIZE-1:0]                      idx
  );
    logic hit;
    hit = 1'b0;
    for (int k = 0; k < ISSUE_WIDTH_INT; k++)
      if (vld[k] && tags[k] == idx) hit = 1'b1;
    return hit;
  endfunction

  // True when a valid lane older than lane writes idx.
  function automatic logic older_write(
    input micro_op_t [DISPATCH_WIDTH-1:0] grp,
    input int                             lane,
    input logic [PRF_INT_INDEX_SIZE-1:0]  idx
  );
    logic hit;
    hit = 1'b0;
    for (int j = 0; j < DISPATCH_WIDTH; j++)
      if (j < lane && grp[j].valid && grp[j].rd_valid && grp[j].rd_prf_int_index == idx)
        hit = 1'b1;
    return hit;
  endfunction

  // Handshake decode; reset suppresses sending and stalling.
  always_comb begin
    send         = (state == FULL) & ~iq_int_full & ~flush & ~reset;
    rename_stall = (state == FULL) & ~send & ~reset;
    any_valid    = 1'b0;
    for (int i = 0; i < DISPATCH_WIDTH; i++) begin
      any_valid     = any_valid | uop_in[i].valid;
      uop_masked[i] = uop_in[i].valid ? uop_in[i] : '0;
    end
    accept = ~rename_stall & ~flush & any_valid;
  end

  // Output group and per-source wait flags, only on a send cycle.
  always_comb begin
    uop_out      = '0;
    rs1_from_ctb = '0;
    rs2_from_ctb = '0;
    if (send) begin
      uop_out = held;
      for (int i = 0; i < DISPATCH_WIDTH; i++) begin
        rs1_from_ctb[i] = held[i].valid & held[i].rs1_valid &
                          (held[i].rs1_prf_int_index != '0) &
                          ((busy[held[i].rs1_prf_int_index] &
                            ~ctb_hit(ctb_prf_int_index, ctb_valid, held[i].rs1_prf_int_index)) |
                           older_write(held, i, held[i].rs1_prf_int_index));
        rs2_from_ctb[i] = held[i].valid & held[i].rs2_valid &
                          (held[i].rs2_prf_int_index != '0) &
                          ((busy[held[i].rs2_prf_int_index] &
                            ~ctb_hit(ctb_prf_int_index, ctb_valid, held[i].rs2_prf_int_index)) |
                           older_write(held, i, held[i].rs2_prf_int_index));
      end
    end
  end

  // Busy table update: tag-bus clears first, then sent destinations set (set wins).
  always_comb begin
    busy_next = busy;
    for (int k = 0; k < ISSUE_WIDTH_INT; k++)
      if (ctb_valid[k]) busy_next[ctb_prf_int_index[k]] = 1'b0;
    if (send)
      for (int i = 0; i < DISPATCH_WIDTH; i++)
        if (held[i].valid && held[i].rd_valid && held[i].rd_prf_int_index != '0)
          busy_next[held[i].rd_prf_int_index] = 1'b1;
    busy_next[0] = 1'b0;
  end

  // Group-holding FSM and busy table registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= EMPTY;
      held  <= '0;
      busy  <= '0;
    end else begin
      busy <= busy_next;
      if (accept) begin
        state <= FULL;
        held  <= uop_masked;
      end else if (send || flush) begin
        state <= EMPTY;
        held  <= '0;
      end
    end
  end

`ifdef DISPATCH_INT_PERF_EN
  // Saturating stall and sent-group counters.
  always_ff @(posedge clock) begin
    if (reset) begin
      perf_stall_cycles <= '0;
      perf_groups_sent  <= '0;
    end else begin
      if (rename_stall && perf_stall_cycles != '1) perf_stall_cycles <= perf_stall_cycles + 32'd1;
      if (send && perf_groups_sent != '1)          perf_groups_sent  <= perf_groups_sent + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dispatch_int.sv
// tb_dispatch_int: directed cycle table plus randomized traffic against a
// behavioural model of the dispatch stage.
module tb_dispatch_int;
  import micro_op_pkg::*;

  localparam int DW = DISPATCH_WIDTH;
  localparam int IW = ISSUE_WIDTH_INT;
  localparam int XW = PRF_INT_INDEX_SIZE;
  localparam int PS = PRF_INT_SIZE;

  logic                      clock;
  logic                      reset;
  logic                      flush;
  micro_op_t [DW-1:0]        uop_in;
  logic                      rename_stall;
  logic                      iq_int_full;
  logic [IW-1:0][XW-1:0]     ctb_prf_int_index;
  logic [IW-1:0]             ctb_valid;
  micro_op_t [DW-1:0]        uop_out;
  logic [DW-1:0]             rs1_from_ctb;
  logic [DW-1:0]             rs2_from_ctb;
  logic                      dbg_state;
  logic [PS-1:0]             dbg_busy;
`ifdef DISPATCH_INT_PERF_EN
  logic [31:0]               perf_stall_cycles;
  logic [31:0]               perf_groups_sent;
`endif

  dispatch_int dut (
    .clock             (clock),
    .reset             (reset),
    .flush             (flush),
    .uop_in            (uop_in),
    .rename_stall      (rename_stall),
    .iq_int_full       (iq_int_full),
    .ctb_prf_int_index (ctb_prf_int_index),
    .ctb_valid         (ctb_valid),
    .uop_out           (uop_out),
    .rs1_from_ctb      (rs1_from_ctb),
    .rs2_from_ctb      (rs2_from_ctb),
    .dbg_state         (dbg_state),
    .dbg_busy          (dbg_busy)
`ifdef DISPATCH_INT_PERF_EN
    ,
    .perf_stall_cycles (perf_stall_cycles),
    .perf_groups_sent  (perf_groups_sent)
`endif
  );

  // Clock
  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    micro_op_t [DW-1:0]    uin;
    logic                  iqf;
    logic                  fl;
    logic                  rst;
    logic [IW-1:0]         cv;
    logic [IW-1:0][XW-1:0] ct;
    bit                    tbl;
    logic                  e_state;
    logic                  e_stall;
    micro_op_t [DW-1:0]    e_out;
    logic [DW-1:0]         e_rs1;
    logic [DW-1:0]         e_rs2;
    int                    chk_idx;
    logic                  chk_val;
  } vec_t;

  int checks = 0;
  int errors = 0;

  // Behavioural model: a held group (or none) and a set of busy registers.
  bit                 m_full;
  micro_op_t [DW-1:0] m_held;
  bit [PS-1:0]        m_busy;
  longint             m_stall_cnt;
  longint             m_sent_cnt;

  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic micro_op_t mu(bit v, bit [15:0] pc, bit s1v, bit [XW-1:0] s1,
                                   bit s2v, bit [XW-1:0] s2, bit dv, bit [XW-1:0] d);
    micro_op_t u;
    u.valid = v; u.pc = pc;
    u.rs1_valid = s1v; u.rs1_prf_int_index = s1;
    u.rs2_valid = s2v; u.rs2_prf_int_index = s2;
    u.rd_valid = dv;   u.rd_prf_int_index = d;
    return u;
  endfunction

  function automatic vec_t idle();
    vec_t v;
    v.uin = '0; v.iqf = 0; v.fl = 0; v.rst = 0; v.cv = '0; v.ct = '0;
    v.tbl = 1; v.e_state = 0; v.e_stall = 0; v.e_out = '0;
    v.e_rs1 = '0; v.e_rs2 = '0; v.chk_idx = -1; v.chk_val = 0;
    return v;
  endfunction

  // Driver: apply one cycle of inputs, compare mid-cycle, advance model at the edge.
  task automatic step(input vec_t v);
    bit                 e_send, e_stall, e_accept, any, hit;
    micro_op_t [DW-1:0] e_out;
    logic [DW-1:0]      e_rs1, e_rs2;
    bit [PS-1:0]        written, n_busy;
    micro_op_t          h;
    uop_in = v.uin; iq_int_full = v.iqf; flush = v.fl; reset = v.rst;
    ctb_valid = v.cv; ctb_prf_int_index = v.ct;
    #4;
    e_send  = m_full && !v.iqf && !v.fl && !v.rst;
    e_stall = m_full && !e_send && !v.rst;
    any = 0;
    for (int i = 0; i < DW; i++) any |= v.uin[i].valid;
    e_accept = !e_stall && !v.fl && any;
    e_out = e_send ? m_held : '0;
    e_rs1 = '0; e_rs2 = '0; written = '0;
    for (int i = 0; i < DW; i++) begin
      h = m_held[i];
      if (e_send && h.valid) begin
        hit = 0;
        for (int k = 0; k < IW; k++) if (v.cv[k] && v.ct[k] == h.rs1_prf_int_index) hit = 1;
        if (h.rs1_valid && h.rs1_prf_int_index != 0 &&
            ((m_busy[h.rs1_prf_int_index] && !hit) || written[h.rs1_prf_int_index])) e_rs1[i] = 1;
        hit = 0;
        for (int k = 0; k < IW; k++) if (v.cv[k] && v.ct[k] == h.rs2_prf_int_index) hit = 1;
        if (h.rs2_valid && h.rs2_prf_int_index != 0 &&
            ((m_busy[h.rs2_prf_int_index] && !hit) || written[h.rs2_prf_int_index])) e_rs2[i] = 1;
        if (h.rd_valid) written[h.rd_prf_int_index] = 1;
      end
    end
    chk("model_state", 160'(dbg_state), 160'(m_full));
    chk("model_stall", 160'(rename_stall), 160'(e_stall));
    chk("model_uop_out", 160'(uop_out), 160'(e_out));
    chk("model_rs1_from_ctb", 160'(rs1_from_ctb), 160'(e_rs1));
    chk("model_rs2_from_ctb", 160'(rs2_from_ctb), 160'(e_rs2));
    chk("model_busy", 160'(dbg_busy), 160'(m_busy));
`ifdef DISPATCH_INT_PERF_EN
    chk("model_perf_stall", 160'(perf_stall_cycles), 160'(m_stall_cnt));
    chk("model_perf_sent", 160'(perf_groups_sent), 160'(m_sent_cnt));
`endif
    if (v.tbl) begin
      chk("tbl_state", 160'(dbg_state), 160'(v.e_state));
      chk("tbl_stall", 160'(rename_stall), 160'(v.e_stall));
      chk("tbl_uop_out", 160'(uop_out), 160'(v.e_out));
      chk("tbl_rs1_from_ctb", 160'(rs1_from_ctb), 160'(v.e_rs1));
      chk("tbl_rs2_from_ctb", 160'(rs2_from_ctb), 160'(v.e_rs2));
      if (v.chk_idx >= 0) chk($sformatf("tbl_busy_%0d", v.chk_idx), 160'(dbg_busy[v.chk_idx]), 160'(v.chk_val));
    end
    // Next model state
    n_busy = m_busy;
    for (int k = 0; k < IW; k++) if (v.cv[k]) n_busy[v.ct[k]] = 0;
    if (e_send)
      for (int i = 0; i < DW; i++)
        if (m_held[i].valid && m_held[i].rd_valid && m_held[i].rd_prf_int_index != 0)
          n_busy[m_held[i].rd_prf_int_index] = 1;
    @(posedge clock);
    if (v.rst) begin
      m_full = 0; m_held = '0; m_busy = '0; m_stall_cnt = 0; m_sent_cnt = 0;
    end else begin
      m_busy = n_busy;
      if (e_stall && m_stall_cnt < 64'hFFFF_FFFF) m_stall_cnt++;
      if (e_send && m_sent_cnt < 64'hFFFF_FFFF) m_sent_cnt++;
      if (e_accept) begin
        m_full = 1;
        for (int i = 0; i < DW; i++) m_held[i] = v.uin[i].valid ? v.uin[i] : '0;
      end else if (e_send || v.fl) begin
        m_full = 0; m_held = '0;
      end
    end
    #1;
  endtask

  vec_t               tbl[$];
  vec_t               r;
  micro_op_t [DW-1:0] ga, gb, gc, gcx, gd, ge;

  initial begin
    reset = 1; flush = 0; iq_int_full = 0; uop_in = '0; ctb_valid = '0; ctb_prf_int_index = '0;
    m_full = 0; m_held = '0; m_busy = '0; m_stall_cnt = 0; m_sent_cnt = 0;
    repeat (2) @(posedge clock);
    #1;

    // Groups used by the directed table
    for (int i = 0; i < DW; i++) ga[i] = mu(1, 16'h100 + 16'(i), 0, 0, 0, 0, 1, XW'(5 + i));
    gb[0] = mu(1, 16'h200, 0, 0, 0, 0, 1, 9);
    gb[1] = mu(1, 16'h201, 0, 0, 0, 0, 1, 10);
    gb[2] = mu(1, 16'h202, 1, 9, 0, 0, 0, 0);
    gb[3] = mu(1, 16'h203, 0, 0, 1, 9, 0, 0);
    gc = '0;
    gc[0] = mu(1, 16'h300, 0, 0, 0, 0, 1, 12);
    gc[2] = mu(0, 16'h302, 1, 3, 0, 0, 1, 30);
    gcx = gc; gcx[2] = '0;
    gd = '0;
    gd[0] = mu(1, 16'h400, 1, 6, 0, 0, 1, 20);
    gd[1] = mu(1, 16'h401, 0, 0, 1, 12, 0, 0);
    ge = '0;
    ge[3] = mu(1, 16'h500, 0, 0, 0, 0, 1, 40);

    // Stimulus table: one record per cycle
    r = idle(); r.chk_idx = 5; r.chk_val = 0; tbl.push_back(r);                     // reset state
    r = idle(); r.uin = ga; tbl.push_back(r);                                       // accept A
    r = idle(); r.e_state = 1; r.e_out = ga; r.chk_idx = 5; tbl.push_back(r);       // send A
    r = idle(); r.chk_idx = 5; r.chk_val = 1; tbl.push_back(r);
    r = idle(); r.chk_idx = 8; r.chk_val = 1; tbl.push_back(r);
    r = idle(); r.uin = gb; tbl.push_back(r);                                       // accept B
    for (int c = 0; c < 3; c++) begin                                               // backpressure
      r = idle(); r.uin = gc; r.iqf = 1; r.e_state = 1; r.e_stall = 1; tbl.push_back(r);
    end
    r = idle(); r.uin = gc; r.e_state = 1; r.e_out = gb;                            // send B, accept C
    r.e_rs1 = 4'b0100; r.e_rs2 = 4'b1000; tbl.push_back(r);
    r = idle(); r.e_state = 1; r.e_out = gcx; r.chk_idx = 9; r.chk_val = 1; tbl.push_back(r);
    r = idle(); r.uin = gd; r.chk_idx = 12; r.chk_val = 1; tbl.push_back(r);
    r = idle(); r.e_state = 1; r.e_out = gd; r.e_rs1 = 4'b0001;                     // bypass + collision
    r.cv = 3'b101; r.ct[2] = 12; r.ct[0] = 20; r.chk_idx = 30; tbl.push_back(r);
    r = idle(); r.chk_idx = 12; r.chk_val = 0; tbl.push_back(r);
    r = idle(); r.chk_idx = 20; r.chk_val = 1; tbl.push_back(r);
    r = idle(); r.uin = ge; tbl.push_back(r);                                       // accept E
    r = idle(); r.iqf = 1; r.e_state = 1; r.e_stall = 1; tbl.push_back(r);
    r = idle(); r.iqf = 1; r.fl = 1; r.e_state = 1; r.e_stall = 1;                  // flush mid-stall
    r.chk_idx = 20; r.chk_val = 1; tbl.push_back(r);
    r = idle(); r.iqf = 1; r.chk_idx = 20; r.chk_val = 1; tbl.push_back(r);
    r = idle(); r.chk_idx = 40; tbl.push_back(r);
    r = idle(); r.uin = ge; tbl.push_back(r);                                       // accept E again
    r = idle(); r.rst = 1; r.e_state = 1; r.chk_idx = 6; r.chk_val = 1; tbl.push_back(r); // reset while FULL
    r = idle(); r.chk_idx = 6; tbl.push_back(r);
    r = idle(); r.chk_idx = 20; tbl.push_back(r);

    foreach (tbl[n]) step(tbl[n]);

    // Randomized traffic
    for (int c = 0; c < 600; c++) begin
      r = idle();
      r.tbl = 0;
      for (int i = 0; i < DW; i++)
        r.uin[i] = mu(1'($urandom_range(0, 1)), 16'($urandom), 1'($urandom_range(0, 1)),
                      XW'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), XW'($urandom_range(0, 15)),
                      1'($urandom_range(0, 1)), XW'($urandom_range(0, 15)));
      if ($urandom_range(0, 3) == 0) r.uin = '0;
      r.iqf = ($urandom_range(0, 2) == 0);
      r.fl  = ($urandom_range(0, 15) == 0);
      r.rst = ($urandom_range(0, 63) == 0);
      for (int k = 0; k < IW; k++) begin
        r.cv[k] = ($urandom_range(0, 2) == 0);
        r.ct[k] = XW'($urandom_range(0, 15));
      end
      step(r);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
